line_clear_ctrl: RTL and testbench

Sequencer that compacts the Tetris playfield after a piece locks: scans the 10×22 block grid bottom-up, drops every full row, shifts the survivors down, zero-fills the top and accumulates the "LINES CLEARED" count. It sits between the game-logic block, which owns the grid register array and pulses `start` on piece lock, and the color mapper, which reads `score`. It drives the grid through a single combinational-read / synchronous-write row port, one row per clock.

---
 rtl/tetris_pkg.sv | 21 ++
 rtl/row_full_detect.sv | 17 +
 rtl/line_clear_ctrl.sv | 135 +++++++++++++
 tb/tb_line_clear_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared Tetris playfield types: grid geometry, row type, line-clear states.
// Used by game logic, line_clear_ctrl and the color mapper.
package tetris_pkg;

  localparam int COLS    = 10;
  localparam int ROWS    = 22;
  localparam int CELL_W  = 3;
  localparam int ROW_W   = $clog2(ROWS);
  localparam int LINES_W = $clog2(ROWS + 1);
  localparam int DATA_W  = COLS * CELL_W;

  typedef logic [COLS-1:0][CELL_W-1:0] row_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    FILL,
    DONE
  } lc_state_t;

endpackage

// File: rtl/row_full_detect.sv
// Flags a grid row whose every cell is nonzero.
// Ports: row (row_t) in, full out; purely combinational.
module row_full_detect
  import tetris_pkg::*;
(
  input  row_t row,
  output logic full
);

  always_comb begin
    full = 1'b1;
    for (int i = 0; i < COLS; i++) begin
      if (row[i] == '0) full = 1'b0;
    end
  end

endmodule

// File: rtl/line_clear_ctrl.sv
// Compacts the playfield bottom-up after a lock: drops full rows, shifts and
// zero-fills, counts lines. Ports: start/score_clr in, grid row port, status.
module line_clear_ctrl
  import tetris_pkg::*;
#(
  parameter int SCORE_W = 10
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               score_clr,
  output logic [ROW_W-1:0]   rd_row,
  input  logic [DATA_W-1:0]  rd_data,
  output logic               wr_en,
  output logic [ROW_W-1:0]   wr_row,
  output logic [DATA_W-1:0]  wr_data,
  output logic               busy,
  output logic               done,
  output logic [LINES_W-1:0] lines,
  output logic [SCORE_W-1:0] score
);

  localparam int SUM_W =
    ((SCORE_W > LINES_W) ? SCORE_W : LINES_W) + 1;
  localparam logic [SUM_W-1:0] SAT =
    SUM_W'((64'd1 << SCORE_W) - 64'd1);

  lc_state_t          state_q, state_d;
  logic [ROW_W-1:0]   r_q, r_d;
  logic [ROW_W-1:0]   w_q, w_d;
  logic [LINES_W-1:0] cnt_q, cnt_d;
  logic [LINES_W-1:0] lines_q;
  logic [SCORE_W-1:0] score_q;
  logic               busy_q, done_q;

  row_t               rd_cells;
  logic               full;
  logic               enter_done;
  logic [SUM_W-1:0]   sum;
  logic [SCORE_W-1:0] score_sat;

  assign rd_cells = rd_data;

  row_full_detect u_full (
    .row  (rd_cells),
    .full (full)
  );

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    w_d     = w_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_row  = '0;
    wr_data = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          r_d     = ROW_W'(ROWS - 1);
          w_d     = ROW_W'(ROWS - 1);
          cnt_d   = '0;
        end
      end
      SCAN: begin
        if (full) begin
          cnt_d = cnt_q + LINES_W'(1);
        end else begin
          // Rows below the first full row are already in place
          if (w_q != r_q) begin
            wr_en   = 1'b1;
            wr_row  = w_q;
            wr_data = rd_data;
          end
          w_d = w_q - ROW_W'(1);
        end
        r_d = r_q - ROW_W'(1);
        if (r_q == '0) begin
          state_d = (cnt_d != '0) ? FILL : DONE;
        end
      end
      FILL: begin
        wr_en  = 1'b1;
        wr_row = w_q;
        w_d    = w_q - ROW_W'(1);
        if (w_q == '0) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign enter_done = (state_d == DONE) && (state_q != DONE);

  assign sum       = SUM_W'(score_q) + SUM_W'(cnt_d);
  assign score_sat = (sum > SAT) ? SCORE_W'(SAT) : SCORE_W'(sum);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      w_q     <= '0;
      cnt_q   <= '0;
      lines_q <= '0;
      score_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      w_q     <= w_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
      if (enter_done) lines_q <= cnt_d;
      if (score_clr) begin
        score_q <= '0;
      end else if (enter_done) begin
        score_q <= score_sat;
      end
    end
  end

  assign rd_row = (state_q == SCAN) ? r_q : '0;
  assign busy   = busy_q;
  assign done   = done_q;
  assign lines  = lines_q;
  assign score  = score_q;

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Scoreboard bench for line_clear_ctrl: directed grid layouts, expected
// writes and pass results queued by stimulus, checked by a monitor.
module tb_line_clear_ctrl;
  import tetris_pkg::*;

  localparam int SW = 3;

  logic               clk;
  logic               reset_n;
  logic               start;
  logic               score_clr;
  logic [ROW_W-1:0]   rd_row;
  logic [DATA_W-1:0]  rd_data;
  logic               wr_en;
  logic [ROW_W-1:0]   wr_row;
  logic [DATA_W-1:0]  wr_data;
  logic               busy;
  logic               done;
  logic [LINES_W-1:0] lines;
  logic [SW-1:0]      score;

  line_clear_ctrl #(.SCORE_W(SW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .score_clr (score_clr),
    .rd_row    (rd_row),
    .rd_data   (rd_data),
    .wr_en     (wr_en),
    .wr_row    (wr_row),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .lines     (lines),
    .score     (score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DATA_W-1:0] grid [ROWS];

  assign rd_data = grid[rd_row];

  always @(posedge clk) begin
    if (wr_en) grid[wr_row] <= wr_data;
  end

  typedef struct {
    int     row;
    longint data;
  } wr_exp_t;

  typedef struct {
    int lines;
    int score;
    int busy_len;
  } done_exp_t;

  wr_exp_t   exp_wr[$];
  done_exp_t exp_done[$];

  int checks   = 0;
  int failures = 0;
  int busy_cnt = 0;

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] mk_row(int val, int hole);
    logic [DATA_W-1:0] v;
    v = '0;
    for (int i = 0; i < COLS; i++) begin
      if (i != hole) v[i*CELL_W +: CELL_W] = CELL_W'(val);
    end
    return v;
  endfunction

  // Monitor: pops expectations whenever the DUT writes or finishes
  always @(negedge clk) begin
    if (!reset_n) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (wr_en) begin
        if (exp_wr.size() == 0) begin
          chk("wr_unexpected_row", wr_row, -1);
        end else begin
          wr_exp_t e;
          e = exp_wr.pop_front();
          chk("wr_row", wr_row, e.row);
          chk("wr_data", wr_data, e.data);
        end
      end
      if (done) begin
        if (exp_done.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          done_exp_t d;
          d = exp_done.pop_front();
          chk("lines", lines, d.lines);
          chk("score", score, d.score);
          chk("busy_len", busy_cnt, d.busy_len);
        end
        busy_cnt = 0;
      end
    end
  end

  logic [DATA_W-1:0] pa, pb, pc, pf;

  task automatic clear_grid();
    for (int i = 0; i < ROWS; i++) grid[i] = '0;
  endtask

  task automatic push_wr(int row, longint data);
    wr_exp_t e;
    e.row  = row;
    e.data = data;
    exp_wr.push_back(e);
  endtask

  task automatic push_done(int l, int s, int b);
    done_exp_t d;
    d.lines    = l;
    d.score    = s;
    d.busy_len = b;
    exp_done.push_back(d);
  endtask

  // Row 21 full, row 20 = A: A drops to 21, 20..1 take empties, 0 zeroed
  task automatic setup_one(int exp_score);
    clear_grid();
    grid[21] = pf;
    grid[20] = pa;
    push_wr(21, pa);
    for (int k = 20; k >= 1; k--) push_wr(k, 0);
    push_wr(0, 0);
    push_done(1, exp_score, 24);
  endtask

  // Rows 21,19,18,17 full; B at 20, C at 16
  task automatic setup_four(int exp_score);
    clear_grid();
    grid[21] = pf;
    grid[20] = pb;
    grid[19] = mk_row(1, -1);
    grid[18] = mk_row(2, -1);
    grid[17] = pf;
    grid[16] = pc;
    push_wr(21, pb);
    push_wr(20, pc);
    for (int k = 19; k >= 4; k--) push_wr(k, 0);
    for (int k = 3; k >= 0; k--) push_wr(k, 0);
    push_done(4, exp_score, 27);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (exp_done.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (exp_done.size() != 0) begin
      chk("done_timeout", t, 0);
      exp_done.delete();
      exp_wr.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int t;
    reset_n   = 1'b0;
    start     = 1'b0;
    score_clr = 1'b0;
    pa = mk_row(5, 0);
    pb = mk_row(2, 9);
    pc = mk_row(6, 4);
    pf = mk_row(7, -1);
    clear_grid();

    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_lines", lines, 0);
    chk("rst_score", score, 0);
    chk("rst_rd_row", rd_row, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Empty grid: no writes, 23 busy cycles
    push_done(0, 0, 23);
    pulse_start();
    wait_done();

    setup_one(1);
    pulse_start();
    wait_done();

    setup_four(5);
    pulse_start();
    wait_done();

    setup_one(6);
    pulse_start();
    wait_done();

    // 6 + 4 saturates at 7
    setup_four(7);
    pulse_start();
    wait_done();

    // Clear mid-SCAN; this pass still adds its line
    setup_one(1);
    pulse_start();
    repeat (3) @(negedge clk);
    score_clr = 1'b1;
    @(negedge clk);
    score_clr = 1'b0;
    chk("score_clr", score, 0);
    wait_done();

    // Extra start mid-SCAN is dropped
    clear_grid();
    push_done(0, 1, 23);
    pulse_start();
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Back-to-back: start in the IDLE cycle right after DONE
    push_done(0, 1, 23);
    push_done(0, 1, 23);
    pulse_start();
    t = 0;
    while (!done && t < 60) begin
      @(negedge clk);
      t++;
    end
    chk("b2b_first_done", done, 1);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done();

    // Asynchronous reset in the middle of FILL
    setup_four(0);
    pulse_start();
    repeat (23) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    #2;
    reset_n = 1'b0;
    exp_wr.delete();
    exp_done.delete();
    #1;
    chk("async_wr_en", wr_en, 0);
    chk("async_busy", busy, 0);
    chk("async_score", score, 0);
    chk("async_lines", lines, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    clear_grid();
    push_done(0, 0, 23);
    pulse_start();
    wait_done();

    chk("wr_queue_drained", exp_wr.size(), 0);
    chk("done_queue_drained", exp_done.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
